// File: rtl/muldiv_hilo_pkg.sv
// Shared opcodes and divider state encoding for the
// multiply/divide/HI-LO execute unit.
package muldiv_hilo_pkg;

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/muldiv_hilo_div_radix2.sv
// Radix-2 restoring divider on magnitudes; signs are
// re-applied to the final step's result.
module div_radix2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic         i_abort,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_quo,
  output logic [W-1:0] o_rem,
  output logic         o_done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          r_active;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic          r_negq;
  logic          r_negr;

  logic [W-1:0]  w_a_abs;
  logic [W-1:0]  w_b_abs;
  logic [W:0]    w_trial;
  logic [W:0]    w_sub;
  logic          w_ge;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quo_nxt;

  assign w_a_abs = (i_signed && i_a[W-1]) ? -i_a : i_a;
  assign w_b_abs = (i_signed && i_b[W-1]) ? -i_b : i_b;

  // dividend bits shift out of r_quo into the partial remainder
  assign w_trial   = {r_rem, r_quo[W-1]};
  assign w_sub     = w_trial - {1'b0, r_div};
  assign w_ge      = ~w_sub[W];
  assign w_rem_nxt = w_ge ? w_sub[W-1:0] : w_trial[W-1:0];
  assign w_quo_nxt = {r_quo[W-2:0], w_ge};

  assign o_done = r_active & ~i_abort & (r_count == LAST);
  assign o_quo  = r_negq ? -w_quo_nxt : w_quo_nxt;
  assign o_rem  = r_negr ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= w_a_abs;
      r_div    <= w_b_abs;
      r_negq   <= i_signed & (i_a[W-1] ^ i_b[W-1]);
      r_negr   <= i_signed & i_a[W-1];
    end else if (r_active) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_count <= r_count + CW'(1);
      if (r_count == LAST)
        r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// EX-stage HI/LO owner: one-cycle multiply, iterative
// divide with pipeline stall, MTHI/MTLO/MFHI/MFLO.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        alucontrol_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                w_go;
  logic                w_is_div;
  logic                w_issue;
  logic                w_div_done;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [2*DATA_W-1:0] w_smul;
  logic [2*DATA_W-1:0] w_umul;

  assign w_go     = en_i & ~flush_i;
  assign w_is_div = (alucontrol_i == EXE_DIV_OP) |
                    (alucontrol_i == EXE_DIVU_OP);
  assign w_issue  = (r_state == DIV_IDLE) & w_go &
                    w_is_div & (b_i != '0);

  // low 2W bits of sign-extended product = signed product
  assign w_smul = {{DATA_W{a_i[DATA_W-1]}}, a_i} *
                  {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign w_umul = {{DATA_W{1'b0}}, a_i} *
                  {{DATA_W{1'b0}}, b_i};

  div_radix2 #(.W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_issue),
    .i_signed (alucontrol_i == EXE_DIV_OP),
    .i_abort  (flush_i),
    .i_a      (a_i),
    .i_b      (b_i),
    .o_quo    (w_quo),
    .o_rem    (w_rem),
    .o_done   (w_div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DIV_IDLE: if (w_issue) w_state_nxt = DIV_RUN;
      DIV_RUN: begin
        if (flush_i)         w_state_nxt = DIV_IDLE;
        else if (w_div_done) w_state_nxt = DIV_DONE;
      end
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    stall_o = w_issue | (r_state == DIV_RUN);
    busy_o  = (r_state != DIV_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == DIV_IDLE && w_go) begin
      unique case (1'b1)
        alucontrol_i == EXE_MULT_OP:  {r_hi, r_lo} <= w_smul;
        alucontrol_i == EXE_MULTU_OP: {r_hi, r_lo} <= w_umul;
        alucontrol_i == EXE_MTHI_OP:  r_hi <= a_i;
        alucontrol_i == EXE_MTLO_OP:  r_lo <= a_i;
        default: ;
      endcase
    end else if (w_div_done) begin
      r_hi <= w_rem;
      r_lo <= w_quo;
    end
  end

  always_comb begin
    result_o = '0;
    unique case (1'b1)
      alucontrol_i == EXE_MFHI_OP: result_o = r_hi;
      alucontrol_i == EXE_MFLO_OP: result_o = r_lo;
      default: ;
    endcase
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Execute-stage consumer of the 8-bit ALU operation code for the multiply/divide/HI-LO group: `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP`, `EXE_MFHI_OP`, `EXE_MFLO_OP`.
- Owns the HI/LO architectural registers.
- Multiplies in one cycle; divides with an iterative radix-2 restoring divider, stalling the pipeline through the hazard unit.
- Sits beside the main ALU in EX; `result_o` is muxed into the EX result for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand and HI/LO width; the divider iterates DATA_W times.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alucontrol_i  in  8  operation code from the decoder (`EXE_*_OP` encodings)
- en_i  in  1  EX instruction valid (not bubble)
- flush_i  in  1  EX flush; cancels any issue and aborts a running divide
- a_i  in  DATA_W  rs operand (forwarded)
- b_i  in  DATA_W  rt operand (forwarded)
- stall_o  out  1  hold IF/ID/EX; high while a divide is issuing or running
- busy_o  out  1  divider FSM not IDLE
- result_o  out  DATA_W  HI for MFHI, LO for MFLO, else 0 (combinational)
- hi_o  out  DATA_W  HI register
- lo_o  out  DATA_W  LO register

Behaviour:
- Reset (async): HI=0, LO=0, FSM=IDLE, count=0; stall_o=0, busy_o=0, result_o=0.
- Define go = en_i & ~flush_i. Writes happen only in IDLE with go.
- MULT: {HI,LO} <= signed 64-bit a*b at the same edge; no stall.
- MULTU: {HI,LO} <= unsigned 64-bit a*b at the same edge; no stall.
- MTHI: HI <= a_i; LO unchanged. MTLO: LO <= a_i; HI unchanged.
- MFHI/MFLO: pure combinational read. An MFHI in the cycle after a MULT sees the new HI; no bypass needed.
- Divide by zero (DIV/DIVU with b_i==0): completes in the issue cycle. HI/LO unchanged, stall_o=0, no FSM entry.
- FSM states: IDLE, RUN, DONE.
- IDLE + go + DIV/DIVU + b≠0 (issue cycle T):
  - stall_o=1 combinationally.
  - At the edge, latch |a|, |b|, quotient-negate flag (sign a ^ sign b, DIV only) and remainder-negate flag (sign a, DIV only).
  - Go to RUN with count=0.
- RUN (cycles T+1..T+32):
  - stall_o=1; one restoring shift/subtract step per edge; count++.
  - At the edge where count==DATA_W-1: apply sign fix-ups, write LO=quotient and HI=remainder, go to DONE.
- DONE (cycle T+33):
  - stall_o=0; new HI/LO visible; pipeline advances.
  - en_i/alucontrol_i are ignored this cycle, so the still-present DIV does not reissue.
  - Next edge: IDLE.
- Total stall is 33 cycles (T..T+32).
- Signed semantics: truncating division; remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- flush_i during RUN or DONE: next edge IDLE, HI/LO unchanged, stall_o drops the following cycle. flush_i in the issue cycle: no issue.
- Asynchronous rst mid-divide: immediate IDLE, HI=LO=0.
- Any other alucontrol_i: no state change; result_o=0.

Decomposition:
- Opcode encodings come from the shared `defines.vh`, unchanged.
- Add to `defines.vh`: `DIV_IDLE`/`DIV_RUN`/`DIV_DONE` 2-bit state constants.
- One natural sub-module, `div_radix2`:
  - inputs: start, operands, signed flag, abort
  - outputs: quotient, remainder, done pulse
  - owns the count and the shift registers.
- muldiv_hilo holds HI/LO, the multiplier, opcode decode and stall generation.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall_o never high.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MFHI -> result_o=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2:
  - stall_o high exactly 33 cycles, en_i held high throughout;
  - then LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - DONE cycle does not restart, busy_o low after 34 cycles.
- DIVU a=100, b=0 -> no stall, HI/LO keep prior values. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 1000/7 with flush_i pulsed at RUN cycle 10 -> stall_o low next cycle, HI/LO unchanged. Reissue completes with LO=142, HI=6.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then rst asserted mid-divide -> immediately HI=LO=0, stall_o=0, busy_o=0.
